// File: rtl/nn_avalon_master.sv
// nn_avalon_master
//   Avalon-MM burst master for the NN accelerator slave port. One host command
//   becomes one Avalon burst: writes stream words from a ready/valid source,
//   reads return words on a one-cycle data-valid output. Slave error responses
//   are reported, and a stuck bus is aborted after TIMEOUT stall cycles.
//
// Ports
//   clk, reset                 clock, synchronous active-high reset
//   cmd_valid/cmd_ready        command handshake (ready only in IDLE)
//   cmd_write/address/count    direction, start address, beat count
//   wr_valid/wr_data/wr_ready  write-data source (ready = word consumed)
//   rd_valid/rd_data           read word out, one cycle per beat
//   done/err_code              completion pulse and status (00 ok, 01 illegal,
//                              10 slave error, 11 timeout)
//   write/read/beginbursttransfer/address/burstcount/writedata   Avalon out
//   readdata/readdatavalid/waitrequest/response                  Avalon in
module nn_avalon_master #(
    parameter int ADDR_W  = 11,
    parameter int DATA_W  = 32,
    parameter int BURST_W = 10,
    parameter int TIMEOUT = 1024
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic               cmd_write,
    input  logic [ADDR_W-1:0]  cmd_address,
    input  logic [BURST_W-1:0] cmd_count,
    input  logic               wr_valid,
    input  logic [DATA_W-1:0]  wr_data,
    output logic               wr_ready,
    output logic               rd_valid,
    output logic [DATA_W-1:0]  rd_data,
    output logic               done,
    output logic [1:0]         err_code,
    output logic               write,
    output logic               read,
    output logic               beginbursttransfer,
    output logic [ADDR_W-1:0]  address,
    output logic [BURST_W-1:0] burstcount,
    output logic [DATA_W-1:0]  writedata,
    input  logic [DATA_W-1:0]  readdata,
    input  logic               readdatavalid,
    input  logic               waitrequest,
    input  logic [1:0]         response
);

    localparam int TO_W = $clog2(TIMEOUT + 1);
    localparam logic [BURST_W-1:0] MAX_CNT = BURST_W'(1 << (BURST_W - 1));

    typedef enum logic [2:0] {IDLE, WR_BURST, RD_REQ, RD_DATA, DONE} state_t;

    state_t state, next_state;

    logic [ADDR_W-1:0]  addr_q;
    logic [BURST_W-1:0] cnt_q;
    logic [BURST_W-1:0] beat_q;
    logic               first_q;
    logic [TO_W-1:0]    tcnt_q;
    logic [1:0]         err_q;
    logic               rd_valid_q;
    logic [DATA_W-1:0]  rd_data_q;

    logic accept, cmd_legal, wr_beat, rd_cmd_ok, rd_beat;
    logic progress, stall, timeout_hit, last_beat, busy_next;

    assign accept    = (state == IDLE) && cmd_valid;
    assign cmd_legal = (cmd_count != '0) && (cmd_count <= MAX_CNT);
    assign wr_beat   = (state == WR_BURST) && wr_valid && !waitrequest;
    assign rd_cmd_ok = (state == RD_REQ) && !waitrequest;
    assign rd_beat   = (state == RD_DATA) && readdatavalid;
    assign progress  = wr_beat || rd_cmd_ok || rd_beat;
    // An empty write source is not a bus stall, so the counter holds then.
    assign stall     = ((state == WR_BURST) && wr_valid && waitrequest) ||
                       ((state == RD_REQ) && waitrequest) ||
                       ((state == RD_DATA) && !readdatavalid);
    assign timeout_hit = stall && (tcnt_q == TO_W'(TIMEOUT - 1));
    assign last_beat   = (beat_q == cnt_q - BURST_W'(1));
    assign busy_next   = (next_state == WR_BURST) || (next_state == RD_REQ) ||
                         (next_state == RD_DATA);

    // State register
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    // Next-state logic
    always_comb begin
        next_state = state;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    if (!cmd_legal)     next_state = DONE;
                    else if (cmd_write) next_state = WR_BURST;
                    else                next_state = RD_REQ;
                end
            end
            WR_BURST: begin
                if (timeout_hit)              next_state = DONE;
                else if (wr_beat && last_beat) next_state = DONE;
            end
            RD_REQ: begin
                if (timeout_hit)    next_state = DONE;
                else if (rd_cmd_ok) next_state = RD_DATA;
            end
            RD_DATA: begin
                if (timeout_hit)               next_state = DONE;
                else if (rd_beat && last_beat) next_state = DONE;
            end
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Outputs
    always_comb begin
        cmd_ready          = (state == IDLE);
        write              = (state == WR_BURST) && wr_valid;
        writedata          = (state == WR_BURST) ? wr_data : '0;
        wr_ready           = (state == WR_BURST) && wr_valid && !waitrequest;
        read               = (state == RD_REQ);
        beginbursttransfer = first_q;
        address            = addr_q;
        burstcount         = cnt_q;
        done               = (state == DONE);
        err_code           = (state == DONE) ? err_q : 2'b00;
        rd_valid           = rd_valid_q;
        rd_data            = rd_data_q;
    end

    // Burst datapath: held bus fields, beat/timeout counters, status
    always_ff @(posedge clk) begin
        if (reset) begin
            addr_q     <= '0;
            cnt_q      <= '0;
            beat_q     <= '0;
            first_q    <= 1'b0;
            tcnt_q     <= '0;
            err_q      <= 2'b00;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            first_q <= accept && cmd_legal;

            // Address/burstcount only live while a burst is on the bus.
            if (accept && cmd_legal) begin
                addr_q <= cmd_address;
                cnt_q  <= cmd_count;
            end else if (!busy_next) begin
                addr_q <= '0;
                cnt_q  <= '0;
            end

            if (accept)                 beat_q <= '0;
            else if (wr_beat || rd_beat) beat_q <= beat_q + BURST_W'(1);

            if (accept || progress || timeout_hit) tcnt_q <= '0;
            else if (stall)                        tcnt_q <= tcnt_q + TO_W'(1);

            // First slave error sticks; a later timeout still wins.
            if (accept)
                err_q <= cmd_legal ? 2'b00 : 2'b01;
            else if (timeout_hit)
                err_q <= 2'b11;
            else if (rd_beat && (response != 2'b00) && (err_q == 2'b00))
                err_q <= 2'b10;

            rd_valid_q <= rd_beat;
            if (rd_beat) rd_data_q <= readdata;
        end
    end

endmodule

// File: tb/tb_nn_avalon_master.sv
module tb_nn_avalon_master;

    localparam int ADDR_W  = 11;
    localparam int DATA_W  = 32;
    localparam int BURST_W = 10;
    localparam int TIMEOUT = 1024;

    logic               clk = 1'b0;
    logic               reset;
    logic               cmd_valid, cmd_ready, cmd_write;
    logic [ADDR_W-1:0]  cmd_address;
    logic [BURST_W-1:0] cmd_count;
    logic               wr_valid, wr_ready;
    logic [DATA_W-1:0]  wr_data;
    logic               rd_valid;
    logic [DATA_W-1:0]  rd_data;
    logic               done;
    logic [1:0]         err_code;
    logic               write, read, beginbursttransfer;
    logic [ADDR_W-1:0]  address;
    logic [BURST_W-1:0] burstcount;
    logic [DATA_W-1:0]  writedata;
    logic [DATA_W-1:0]  readdata;
    logic               readdatavalid, waitrequest;
    logic [1:0]         response;

    nn_avalon_master #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .BURST_W(BURST_W), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_address(cmd_address), .cmd_count(cmd_count),
        .wr_valid(wr_valid), .wr_data(wr_data), .wr_ready(wr_ready),
        .rd_valid(rd_valid), .rd_data(rd_data),
        .done(done), .err_code(err_code),
        .write(write), .read(read), .beginbursttransfer(beginbursttransfer),
        .address(address), .burstcount(burstcount), .writedata(writedata),
        .readdata(readdata), .readdatavalid(readdatavalid),
        .waitrequest(waitrequest), .response(response)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        wr;
        logic [10:0] addr;
        logic [9:0]  cnt;
        logic [15:0] wait_m;   // per-cycle waitrequest (request phase for reads)
        logic [15:0] gap_m;    // per-cycle wr_valid / readdatavalid gap
        logic [31:0] base;
        int          eb2;      // beat index answered with response 10
        int          eb3;      // beat index answered with response 11
        logic [1:0]  exp_err;
    } vec_t;

    int n_vec = 0;
    int n_err = 0;
    vec_t vecs[8];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic mbit(input logic [15:0] m, input int c);
        logic [3:0] i;
        i = c[3:0];
        return (c < 16) ? m[i] : 1'b0;
    endfunction

    task automatic idle_inputs();
        cmd_valid = 0; cmd_write = 0; cmd_address = '0; cmd_count = '0;
        wr_valid = 0; wr_data = '0;
        readdata = '0; readdatavalid = 0; waitrequest = 0; response = 2'b00;
    endtask

    task automatic run_vec(input vec_t v);
        int  acc, sent;
        bit  fin, wv, wq, rdv, req_done, prev_rdv, exp_done;
        logic [31:0] prev_word;
        cmd_valid = 1; cmd_write = v.wr; cmd_address = v.addr; cmd_count = v.cnt;
        @(negedge clk);
        chk("cmd_ready", cmd_ready, 1);
        tick();
        cmd_valid = 0;
        fin = 0;
        if (v.exp_err == 2'b01) begin
            @(negedge clk);
            chk("ill_done", done, 1);
            chk("ill_err", err_code, 2'b01);
            chk("ill_bus", {write, read, beginbursttransfer, burstcount}, 0);
            tick();
            @(negedge clk);
            chk("ill_done_pulse", done, 0);
            fin = 1;
        end else if (v.wr) begin
            acc = 0;
            for (int c = 0; c < 1200 && !fin; c++) begin
                exp_done = (acc == int'(v.cnt));
                wv = exp_done ? 1'b0 : !mbit(v.gap_m, c);
                wq = mbit(v.wait_m, c);
                wr_valid = wv; waitrequest = wq; wr_data = v.base + acc;
                @(negedge clk);
                chk("wr_done", done, exp_done);
                if (exp_done) begin
                    chk("wr_err", err_code, v.exp_err);
                    chk("wr_write_off", write, 0);
                    fin = 1;
                end else begin
                    chk("wr_addr", address, v.addr);
                    chk("wr_bcnt", burstcount, v.cnt);
                    chk("wr_begin", beginbursttransfer, c == 0);
                    chk("wr_write", write, wv);
                    chk("wr_ready", wr_ready, wv && !wq);
                    if (wv) chk("wr_wdata", writedata, v.base + acc);
                    if (wv && !wq) acc++;
                end
                tick();
            end
            wr_valid = 0; waitrequest = 0;
        end else begin
            sent = 0; req_done = 0; prev_rdv = 0; prev_word = '0;
            for (int c = 0; c < 1200 && !fin; c++) begin
                exp_done = prev_rdv && (sent == int'(v.cnt));
                waitrequest = req_done ? 1'b0 : mbit(v.wait_m, c);
                rdv = req_done && (sent < int'(v.cnt)) && !mbit(v.gap_m, c);
                readdatavalid = rdv;
                readdata = v.base + sent;
                response = !rdv ? 2'b00 : (sent == v.eb2) ? 2'b10 :
                           (sent == v.eb3) ? 2'b11 : 2'b00;
                @(negedge clk);
                chk("rd_done", done, exp_done);
                chk("rd_valid", rd_valid, prev_rdv);
                if (prev_rdv) chk("rd_data", rd_data, prev_word);
                if (exp_done) begin
                    chk("rd_err", err_code, v.exp_err);
                    chk("rd_read_off", read, 0);
                    fin = 1;
                end else begin
                    chk("rd_read", read, !req_done);
                    chk("rd_begin", beginbursttransfer, c == 0);
                    chk("rd_addr", address, v.addr);
                    chk("rd_bcnt", burstcount, v.cnt);
                end
                prev_rdv = rdv;
                prev_word = v.base + sent;
                if (rdv) sent++;
                if (!req_done && !waitrequest) req_done = 1;
                tick();
            end
            readdatavalid = 0; response = 2'b00; waitrequest = 0;
        end
        chk("txn_budget", fin, 1);
        @(negedge clk);
        chk("back_idle", cmd_ready, 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int  cyc, rcnt;
        bit  seen;
        vec_t v2;

        //          wr  addr     cnt  wait_m        gap_m                base          eb2 eb3 err
        vecs[0] = '{1'b1, 11'h010, 10'd4,   16'h0000, 16'h0000,           32'h1000_0000, -1, -1, 2'b00};
        vecs[1] = '{1'b1, 11'h020, 10'd3,   16'h0006, 16'h0010,           32'h2000_0000, -1, -1, 2'b00};
        vecs[2] = '{1'b0, 11'h400, 10'd8,   16'h0000, 16'b0000_0101_0010_0100, 32'h0000_00A0, -1, -1, 2'b00};
        vecs[3] = '{1'b0, 11'h100, 10'd4,   16'h0000, 16'h0000,           32'h0000_0C00,  2,  3, 2'b10};
        vecs[4] = '{1'b1, 11'h030, 10'd0,   16'h0000, 16'h0000,           32'h0,         -1, -1, 2'b01};
        vecs[5] = '{1'b0, 11'h030, 10'd513, 16'h0000, 16'h0000,           32'h0,         -1, -1, 2'b01};
        vecs[6] = '{1'b1, 11'h7FF, 10'd512, 16'h0000, 16'h0000,           32'h3000_0000, -1, -1, 2'b00};
        vecs[7] = '{1'b0, 11'h555, 10'd1,   16'h0007, 16'h0000,           32'h0000_7777, -1, -1, 2'b00};

        idle_inputs();
        reset = 1;
        repeat (3) tick();
        @(negedge clk);
        chk("rst_outs", {write, read, beginbursttransfer, address, burstcount, writedata,
                         wr_ready, rd_valid, rd_data, done, err_code}, 0);
        reset = 0;
        tick();
        @(negedge clk);
        chk("rst_cmd_ready", cmd_ready, 1);
        chk("rst_done", done, 0);

        for (int i = 0; i < 8; i++) begin
            tick();
            run_vec(vecs[i]);
        end

        // Source gap longer than TIMEOUT with waitrequest high must not time out.
        tick();
        cmd_valid = 1; cmd_write = 1; cmd_address = 11'h060; cmd_count = 10'd2;
        tick();
        cmd_valid = 0;
        wr_valid = 1; wr_data = 32'hAAAA_0000; waitrequest = 0;
        @(negedge clk);
        chk("gap_beat0", wr_ready, 1);
        tick();
        wr_valid = 0; waitrequest = 1; seen = 0;
        for (int c = 0; c < TIMEOUT + 16; c++) begin
            @(negedge clk);
            if (done || write) seen = 1;
            tick();
        end
        chk("gap_no_timeout", seen, 0);
        wr_valid = 1; wr_data = 32'hAAAA_0001; waitrequest = 0;
        @(negedge clk);
        chk("gap_beat1", wr_ready, 1);
        chk("gap_wdata1", writedata, 32'hAAAA_0001);
        tick();
        wr_valid = 0;
        @(negedge clk);
        chk("gap_done", done, 1);
        chk("gap_err", err_code, 2'b00);

        // Read with waitrequest stuck high: TIMEOUT read cycles then abort.
        tick();
        cmd_valid = 1; cmd_write = 0; cmd_address = 11'h050; cmd_count = 10'd2;
        tick();
        cmd_valid = 0; waitrequest = 1;
        rcnt = 0; seen = 0;
        for (cyc = 0; cyc < TIMEOUT + 50 && !seen; cyc++) begin
            @(negedge clk);
            if (done) begin
                seen = 1;
                chk("to_err", err_code, 2'b11);
                chk("to_read_off", read, 0);
            end else if (read) rcnt++;
            tick();
        end
        chk("to_done_seen", seen, 1);
        chk("to_read_cycles", rcnt, TIMEOUT);
        waitrequest = 0;

        // Reset in the middle of a 6-beat read after 2 beats.
        tick();
        cmd_valid = 1; cmd_write = 0; cmd_address = 11'h200; cmd_count = 10'd6;
        tick();
        cmd_valid = 0; waitrequest = 0;            // request accepted this cycle
        tick();
        readdatavalid = 1; readdata = 32'hB0;      // beat 0
        tick();
        readdata = 32'hB1;                         // beat 1
        tick();
        readdata = 32'hB2;
        @(negedge clk);
        chk("rst_mid_rdv", rd_valid, 1);
        chk("rst_mid_rdata", rd_data, 32'hB1);
        reset = 1;
        tick();
        reset = 0; readdatavalid = 0;
        @(negedge clk);
        chk("rst_mid_outs", {write, read, beginbursttransfer, address, burstcount, writedata,
                             wr_ready, rd_valid, rd_data, done, err_code}, 0);
        seen = 0;
        for (int c = 0; c < 4; c++) begin
            tick();
            @(negedge clk);
            if (done || rd_valid) seen = 1;
        end
        chk("rst_mid_no_done", seen, 0);
        v2 = '{1'b0, 11'h204, 10'd2, 16'h0000, 16'h0002, 32'h0000_0D00, -1, -1, 2'b00};
        tick();
        run_vec(v2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/nn_avalon_master.md
# nn_avalon_master

Avalon-MM burst master that drives the neural network accelerator's slave port from the host/test side. It converts single commands into Avalon bursts. A write command streams pixel or weight words from a ready/valid source. A read command fetches result words and presents them on a data-valid output. The block tracks beats, checks slave responses, and aborts on a stuck bus with a timeout. It sits between a host sequencer (or DMA front end) and the accelerator's `write/read/address/burstcount/waitrequest/readdatavalid` interface.

## Interface
- `ADDR_W`, 11: Avalon address width.
- `DATA_W`, 32: Avalon data width.
- `BURST_W`, 10: burstcount width; legal counts are 1..2^(BURST_W-1) (512).
- `TIMEOUT`, 1024: stall cycles without progress before abort.

- `clk` in 1: clock.
- `reset` in 1: synchronous, active-high reset.
- `cmd_valid` in 1: command request.
- `cmd_ready` out 1: high only in IDLE.
- `cmd_write` in 1: 1 = write burst, 0 = read burst.
- `cmd_address` in ADDR_W: burst start address.
- `cmd_count` in BURST_W: number of beats.
- `wr_valid` in 1: source word available.
- `wr_data` in DATA_W: source word.
- `wr_ready` out 1: source word consumed this cycle.
- `rd_valid` out 1: read word valid (1 cycle).
- `rd_data` out DATA_W: read word.
- `done` out 1: 1-cycle command-complete pulse.
- `err_code` out 2: 00 OK, 01 illegal command, 10 slave error response, 11 timeout; valid while `done`=1.
- `write`, `read`, `beginbursttransfer` out 1: Avalon controls.
- `address` out ADDR_W, `burstcount` out BURST_W, `writedata` out DATA_W: Avalon outputs.
- `readdata` in DATA_W, `readdatavalid` in 1, `waitrequest` in 1, `response` in 2: Avalon inputs.

## Operation
- States: IDLE, WR_BURST, RD_REQ, RD_DATA, DONE.
- IDLE
  - Accept on `cmd_valid && cmd_ready`.
  - Latch address, count and direction.
  - `cmd_count`==0 or >512 → DONE with `err_code`=01. No bus activity.
  - Otherwise go to WR_BURST or RD_REQ.
- Bus hold: `address` and `burstcount` are registered and held constant for the whole burst.
- `beginbursttransfer`: high exactly the first cycle of WR_BURST or RD_REQ, regardless of `waitrequest`.
- WR_BURST
  - `write` = `wr_valid`.
  - `writedata` = `wr_data`.
  - `wr_ready` = `wr_valid && !waitrequest`.
  - A beat is accepted when `write && !waitrequest`. The beat counter increments on each accepted beat.
  - The last beat goes to DONE.
- RD_REQ
  - `read`=1 until `!waitrequest`, then go to RD_DATA.
- RD_DATA
  - Each `readdatavalid` registers `readdata`/`response` to `rd_data`/`rd_valid` one cycle later and increments the beat counter.
  - The first nonzero `response` latches `err_code`=10; later beats do not overwrite it. All beats are still delivered.
  - The last beat goes to DONE.
- Timeout counter
  - Clears on every progress event: accepted write beat, accepted read command, `readdatavalid`.
  - Counts while `write` or `read` is asserted with `waitrequest`=1, and every cycle in RD_DATA.
  - Holds while WR_BURST has `wr_valid`=0, because the stall is on the source side.
  - Reaching TIMEOUT → DONE with `err_code`=11. Controls drop the same edge.
- DONE: `done`=1 for one cycle, then IDLE.
- `readdatavalid` outside RD_DATA is ignored (no `rd_valid`).
- `reset` mid-burst: all state, counters and outputs clear at the next edge. The burst is abandoned and no `done` is issued.

## Timing
- Reset values: all outputs 0, except `cmd_ready`=1 once in IDLE after reset release.
- Command accepted at edge N → `beginbursttransfer`, `address`, `burstcount` valid in cycle N+1.
- Write: at most one beat per cycle. Last beat accepted in cycle K → `done` in cycle K+1.
- Read: `readdatavalid` in cycle M → `rd_valid`/`rd_data` in cycle M+1. Last beat in M → `done` and the final `rd_valid` both in M+1.
- Back-to-back: a new command is accepted no earlier than the cycle after `done`. Minimum gap is 1 idle cycle.
- Timeout: abort `done` occurs TIMEOUT cycles after the last progress event.

## Test plan
- Write burst: address 0x010, count 4, `wr_valid` always 1, `waitrequest`=0 → 4 consecutive `write` cycles with `address`=0x010, `burstcount`=4; `beginbursttransfer` only in cycle 1; `done`, `err_code`=00.
- Write backpressure: count 3, `waitrequest` high for 2 cycles on beat 2, `wr_valid` gap of 1 cycle → exactly 3 `wr_ready` pulses; data order preserved; timeout counter does not advance during the `wr_valid` gap.
- Read burst: address 0x400, count 8, slave returns 0xA0..0xA7 with gaps → 8 `rd_valid` beats in order, each 1 cycle after `readdatavalid`; `done` with the last beat; `err_code`=00.
- Slave error: 4-beat read, beat 3 has `response`=10, beat 4 has `response`=11 → all 4 words delivered; `err_code`=10.
- Illegal command and timeout: `cmd_count`=0 → `done` with 01 and no bus activity. `waitrequest` stuck high on read → `read` drops and `done` with 11 after TIMEOUT cycles.
- Reset mid-read after 2 of 6 beats → all outputs 0 next cycle, no `done`; a following 2-beat read completes with 00.
